// File: rtl/oam_dma.sv
// oam_dma: sprite DMA engine. It halts the CPU and copies one page of memory into PPU OAMDATA,
// using alternating get/put CPU cycles with an optional alignment cycle.
module oam_dma #(
   parameter logic [2:0] PPU_OAMDATA_ADDR = 3'h4,
   parameter int         BYTES            = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_ce,
   input  logic        dma_start,
   input  logic [7:0]  dma_page,
   output logic        halt,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   input  logic [7:0]  mem_data_i,
   output logic        ppu_cs,
   output logic        ppu_rw,
   output logic [2:0]  ppu_addr,
   output logic [7:0]  ppu_data_o,
   output logic        busy
);
   typedef enum logic [2:0] {IDLE, HALT, ALIGN, GET, PUT} state_t;
   localparam logic [7:0] LAST = 8'(BYTES - 1);
   state_t     state;
   logic [7:0] page, idx, data_r;
   logic       cyc_odd;
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         page    <= '0;
         idx     <= '0;
         data_r  <= '0;
         cyc_odd <= 1'b0;
      end else begin
         if (cpu_ce) cyc_odd <= ~cyc_odd;
         case (state)
            IDLE: if (dma_start) begin
               page  <= dma_page;
               idx   <= '0;
               state <= HALT;
            end
            // an odd current cycle means the next one is even, so reads can start immediately
            HALT:  if (cpu_ce) state <= cyc_odd ? GET : ALIGN;
            ALIGN: if (cpu_ce) state <= GET;
            GET: if (cpu_ce) begin
               data_r <= mem_data_i;
               state  <= PUT;
            end
            PUT: if (cpu_ce) begin
               if (idx == LAST) state <= IDLE;
               else begin
                  idx   <= idx + 8'd1;
                  state <= GET;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign halt       = state != IDLE;
   assign busy       = halt;
   assign mem_rd     = state == GET;
   assign mem_addr   = mem_rd ? {page, idx} : '0;
   assign ppu_cs     = state == PUT;
   assign ppu_rw     = ~ppu_cs;
   assign ppu_addr   = PPU_OAMDATA_ADDR;
   assign ppu_data_o = ppu_cs ? data_r : '0;
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed checks of a full-page DMA instance and a 4-byte instance.
module tb_oam_dma;
   logic        clk = 0, rst = 1, cpu_ce = 0, dma_start = 0, start4 = 0;
   logic [7:0]  dma_page = 0, page4 = 0;
   logic        halt, mem_rd, ppu_cs, ppu_rw, busy;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data_i, ppu_data_o;
   logic [2:0]  ppu_addr;
   logic        halt4, mem_rd4, ppu_cs4, ppu_rw4, busy4;
   logic [15:0] mem_addr4;
   logic [7:0]  mem_data4, ppu_data4;
   logic [2:0]  ppu_addr4;
   int          checks = 0, errors = 0;
   int          div = 3, ph = 0, ce_total = 0;
   int          n_halt_ce = 0, n_rd = 0, n_wr = 0;
   logic [7:0]  exp_page = 0;
   logic        prev_halt = 0, prev_rd = 0, prev_cs = 0;
   logic [15:0] last_addr = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_f(input logic [15:0] a);
      return 8'(a[7:0] * 3 + a[15:8] + 8'h11);
   endfunction
   assign mem_data_i = mem_f(mem_addr);
   assign mem_data4  = mem_f(mem_addr4);

   oam_dma dut (
      .clk(clk), .rst(rst), .cpu_ce(cpu_ce), .dma_start(dma_start), .dma_page(dma_page),
      .halt(halt), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data_i(mem_data_i),
      .ppu_cs(ppu_cs), .ppu_rw(ppu_rw), .ppu_addr(ppu_addr), .ppu_data_o(ppu_data_o), .busy(busy)
   );
   oam_dma #(.BYTES(4)) dut4 (
      .clk(clk), .rst(rst), .cpu_ce(cpu_ce), .dma_start(start4), .dma_page(page4),
      .halt(halt4), .mem_rd(mem_rd4), .mem_addr(mem_addr4), .mem_data_i(mem_data4),
      .ppu_cs(ppu_cs4), .ppu_rw(ppu_rw4), .ppu_addr(ppu_addr4), .ppu_data_o(ppu_data4), .busy(busy4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one clk: inputs change on the falling edge, outputs are observed 1ns after the rising edge
   task automatic tick();
      @(negedge clk);
      ph = (ph >= div - 1) ? 0 : ph + 1;
      cpu_ce = (ph == div - 1);
      @(posedge clk);
      #1;
      if (rst) ce_total = 0;
      else if (cpu_ce) ce_total++;
      if (cpu_ce && prev_halt && !rst) n_halt_ce++;
      if (mem_rd && !prev_rd) begin
         last_addr = {exp_page, 8'(n_rd)};
         check("rd_addr", mem_addr, last_addr);
         check("get_even", ce_total % 2, 0);
         n_rd++;
      end
      if (ppu_cs && !prev_cs) begin
         check("wr_addr", ppu_addr, 4);
         check("wr_rw", ppu_rw, 0);
         check("wr_data", ppu_data_o, mem_f(last_addr));
         n_wr++;
      end
      prev_halt = halt;
      prev_rd   = mem_rd;
      prev_cs   = ppu_cs;
   endtask

   task automatic run_xfer(input logic [7:0] page, input int want_odd, input int inject_at, input int abort_at);
      bit injected = 0;
      exp_page = page;
      n_rd = 0; n_wr = 0; n_halt_ce = 0;
      while (!(ce_total % 2 == want_odd && ph == div - 1)) tick();
      dma_page = page;
      dma_start = 1;
      tick();
      dma_start = 0;
      dma_page = 8'hEE;
      check("busy_start", busy, 1);
      for (int t = 0; t < 3000 && busy; t++) begin
         if (n_rd == inject_at && !injected) begin
            injected = 1;
            dma_page = 8'h07;
            dma_start = 1;
         end
         tick();
         dma_start = 0;
         if (abort_at >= 0 && n_wr == abort_at + 1) return;
      end
      check("done", busy, 0);
      check("halt_ce", n_halt_ce, want_odd ? 513 : 514);
      check("n_rd", n_rd, 256);
      check("n_wr", n_wr, 256);
   endtask

   initial begin
      repeat (3) tick();
      check("rst_halt", halt, 0);
      check("rst_busy", busy, 0);
      check("rst_mem_rd", mem_rd, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_ppu_cs", ppu_cs, 0);
      check("rst_ppu_rw", ppu_rw, 1);
      check("rst_ppu_addr", ppu_addr, 4);
      check("rst_ppu_data", ppu_data_o, 0);
      check("rst_busy4", busy4, 0);
      rst = 0;
      tick();
      run_xfer(8'h02, 1, -1, -1);
      run_xfer(8'h02, 0, -1, -1);
      run_xfer(8'h02, 1, 100, -1);
      run_xfer(8'h02, 0, -1, 37);
      check("abort_in_put", ppu_cs, 1);
      rst = 1;
      tick();
      check("abort_halt", halt, 0);
      check("abort_ppu_cs", ppu_cs, 0);
      check("abort_ppu_rw", ppu_rw, 1);
      check("abort_busy", busy, 0);
      rst = 0;
      repeat (30) tick();
      check("abort_no_wr", n_wr, 38);
      check("abort_idle", busy, 0);
      run_xfer(8'h03, 1, -1, -1);
      div = 1;
      for (int w = 0; w < 2; w++) begin
         int exp_n, b4, rises;
         logic [15:0] bits, la;
         logic pcs;
         exp_n = (w == 1) ? 9 : 10;
         b4 = 0; rises = 0; bits = 0; la = 0; pcs = 0;
         while (ce_total % 2 == w) tick();
         page4 = 8'h11;
         start4 = 1;
         tick();
         start4 = 0;
         for (int t = 0; t < 20 && busy4; t++) begin
            b4++;
            bits = {bits[14:0], mem_rd4};
            if (mem_rd4) la = mem_addr4;
            if (ppu_cs4 && !pcs) begin
               rises++;
               check("b4_data", ppu_data4, mem_f(la));
            end
            pcs = ppu_cs4;
            if (b4 == exp_n) start4 = 1;
            tick();
            start4 = 0;
         end
         check("b4_busy_clks", b4, exp_n);
         check("b4_rd_pattern", bits, 16'h00AA);
         check("b4_writes", rises, 4);
         check("b4_last_addr", la, 16'h1103);
         tick();
         check("b4_restart_ignored", busy4, 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
